// File: rtl/adder_arbiter.sv
// adder_arbiter: lets two requesters share one registered adder.
//
// A request is accepted in IDLE. Its mode and operands are latched and
// driven to the adder during EXEC. The adder result is captured in CAPT,
// one cycle after EXEC. RESP then offers the result to the requester that
// owns it, until that requester takes it.
//
// Ports
//   clk, rst                      clock (rising edge), async active-low reset
//   reqN_valid_i / reqN_ready_o   request handshake (ready is combinational, IDLE only)
//   reqN_f_i, reqN_a_i, reqN_b_i  mode and operands
//   rspN_valid_o / rspN_ready_i   response handshake
//   rspN_y_o                      result
//   adder_f_o, adder_a_o, adder_b_o   drive the shared adder
//   adder_y_i                     registered adder result
//   busy_o                        high whenever the FSM is not in IDLE
//
// Configuration
//   ADDER_ARB_RR_EN  defined   : round-robin tie break
//                    undefined : fixed priority, requester 0 wins ties
//
// Mode encodings are defined in define.vh (adder_unsigned, adder_1sComplement,
// adder_2sComplement). This block forwards them unchanged, including 2'b11.

module adder_arbiter #(
    parameter int W  = 4,
    parameter int FW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid_i,
    output logic          req0_ready_o,
    input  logic [FW-1:0] req0_f_i,
    input  logic [W-1:0]  req0_a_i,
    input  logic [W-1:0]  req0_b_i,
    input  logic          req1_valid_i,
    output logic          req1_ready_o,
    input  logic [FW-1:0] req1_f_i,
    input  logic [W-1:0]  req1_a_i,
    input  logic [W-1:0]  req1_b_i,
    output logic          rsp0_valid_o,
    input  logic          rsp0_ready_i,
    output logic [W-1:0]  rsp0_y_o,
    output logic          rsp1_valid_o,
    input  logic          rsp1_ready_i,
    output logic [W-1:0]  rsp1_y_o,
    output logic [FW-1:0] adder_f_o,
    output logic [W-1:0]  adder_a_o,
    output logic [W-1:0]  adder_b_o,
    input  logic [W-1:0]  adder_y_i,
    output logic          busy_o
);

    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] f_q;
    logic [W-1:0]  a_q, b_q, y_q;
    logic          own_q;     // requester that owns the operation in flight
    logic          any_req;
    logic          accept;
    logic          win;       // 0: requester 0, 1: requester 1

    assign any_req = req0_valid_i | req1_valid_i;
    assign accept  = (state_q == IDLE) && any_req;

`ifdef ADDER_ARB_RR_EN
    // prio_q names the requester that wins the next tie.
    logic prio_q;

    assign win = (req0_valid_i && req1_valid_i) ? prio_q : req1_valid_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        prio_q <= 1'b0;
        else if (accept) prio_q <= ~win;
    end
`else
    // Fixed priority: requester 1 wins only when requester 0 is idle.
    assign win = ~req0_valid_i;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next state and handshake outputs
    always_comb begin
        state_d      = state_q;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        rsp0_valid_o = 1'b0;
        rsp1_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                // Reset is included so that ready stays low while reset is held.
                req0_ready_o = accept && !win && rst;
                req1_ready_o = accept &&  win && rst;
                if (any_req) state_d = EXEC;
            end
            EXEC: state_d = CAPT;
            CAPT: state_d = RESP;
            RESP: begin
                rsp0_valid_o = !own_q;
                rsp1_valid_o =  own_q;
                if (own_q ? rsp1_ready_i : rsp0_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand, owner and result registers. The operand registers drive the
    // adder directly, so the adder inputs change only when entering EXEC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            y_q   <= '0;
            own_q <= 1'b0;
        end else begin
            if (accept) begin
                own_q <= win;
                f_q   <= win ? req1_f_i : req0_f_i;
                a_q   <= win ? req1_a_i : req0_a_i;
                b_q   <= win ? req1_b_i : req0_b_i;
            end
            if (state_q == CAPT) y_q <= adder_y_i;
        end
    end

    assign adder_f_o = f_q;
    assign adder_a_o = a_q;
    assign adder_b_o = b_q;
    // Result data can be shared by both requesters because only the owner sees valid.
    assign rsp0_y_o  = y_q;
    assign rsp1_y_o  = y_q;
    assign busy_o    = (state_q != IDLE);

endmodule
